// File: rtl/fpmul_pkg.sv
// fpmul_pkg: flag bit positions, arbiter FSM states and the all-ones exponent helper.
package fpmul_pkg;
  localparam int FLG_INF  = 4;
  localparam int FLG_NAN  = 3;
  localparam int FLG_ZERO = 2;
  localparam int FLG_OVF  = 1;
  localparam int FLG_UNF  = 0;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic logic [31:0] exp_ones(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/fpmul_arbiter_if.sv
// fpmul_arbiter_if: two request channels (valid/ready/x/y), one tagged response channel
// (valid/ready/id/result/flags) and the op_count status; slave = arbiter side, master = environment side.
interface fpmul_arbiter_if #(parameter int BITS = 32);
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [BITS-1:0] req0_x, req0_y, req1_x, req1_y;
  logic            resp_valid, resp_ready, resp_id;
  logic [BITS-1:0] resp_result;
  logic [4:0]      resp_flags;
  logic [15:0]     op_count;
  modport slave (
    input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_result, resp_flags, op_count
  );
  modport master (
    output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_result, resp_flags, op_count
  );
endinterface

// File: rtl/fp_mul_core.sv
// fp_mul_core: combinational truncating FP multiply; x_i, y_i -> result_o, flags_o {inf,nan,zero,ovf,unf}.
module fp_mul_core import fpmul_pkg::*; #(
  parameter int EXP  = 8,
  parameter int MAN  = 23,
  parameter int BITS = MAN + EXP + 1,
  parameter int BIAS = 2 ** (EXP - 1) - 1
) (
  input  logic [BITS-1:0] x_i,
  input  logic [BITS-1:0] y_i,
  output logic [BITS-1:0] result_o,
  output logic [4:0]      flags_o
);
  localparam logic [EXP-1:0]  EMAX    = EXP'(exp_ones(EXP));
  localparam logic [BITS-1:0] INF_RES = {1'b0, EMAX, {MAN{1'b0}}};
  logic xs, ys;
  logic [EXP-1:0] ex, ey, pe;
  logic [MAN-1:0] mx, my, pm;
  logic [2*MAN+1:0] prod;
  logic [EXP:0] esum;
  logic zero, nan, inf, unf, ovf;
  assign {xs, ex, mx} = x_i;
  assign {ys, ey, my} = y_i;
  assign prod = {{(MAN+1){1'b0}}, 1'b1, mx} * {{(MAN+1){1'b0}}, 1'b1, my};
  assign esum = {1'b0, ex} + {1'b0, ey};
  // Product in [2,4) is renormalised by one position, bumping the exponent.
  assign pe = ex + ey - EXP'(BIAS) + {{(EXP-1){1'b0}}, prod[2*MAN+1]};
  assign pm = prod[2*MAN+1] ? prod[2*MAN:MAN+1] : prod[2*MAN-1:MAN];
  assign zero = (x_i[BITS-2:0] == '0) | (y_i[BITS-2:0] == '0) | ({pe, pm} == '0);
  assign nan  = (ex == EMAX && mx != '0) | (ey == EMAX && my != '0) | (pe == EMAX && pm != '0);
  assign inf  = (ex == EMAX && mx == '0) | (ey == EMAX && my == '0) | (pe == EMAX && pm == '0);
  assign unf  = esum < (EXP+1)'(BIAS);
  assign ovf  = esum > (EXP+1)'(3 * BIAS);
  always_comb begin
    flags_o  = '0;
    result_o = {xs ^ ys, pe, pm};
    if (zero) begin
      flags_o[FLG_ZERO] = 1'b1;
      result_o = '0;
    end else if (nan) begin
      flags_o[FLG_NAN] = 1'b1;
      result_o = INF_RES;
    end else if (inf) begin
      flags_o[FLG_INF] = 1'b1;
      result_o = INF_RES;
    end else if (unf) begin
      flags_o[FLG_UNF] = 1'b1;
      result_o = '0;
    end else if (ovf) begin
      flags_o[FLG_OVF] = 1'b1;
      result_o = INF_RES;
    end
  end
endmodule

// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: round-robin share of one registered fp_mul_core between two requesters.
// Ports: clk, resetn (sync, active-low), bus (fpmul_arbiter_if.slave: req0/req1 channels, response channel, op_count).
module fpmul_arbiter import fpmul_pkg::*; #(
  parameter int EXP  = 8,
  parameter int MAN  = 23,
  parameter int BITS = MAN + EXP + 1,
  parameter int BIAS = 2 ** (EXP - 1) - 1
) (
  input logic              clk,
  input logic              resetn,
  fpmul_arbiter_if.slave   bus
);
  state_t state_q, state_d;
  logic rr_q, id_q;
  logic [BITS-1:0] x_q, y_q, res_q, core_res;
  logic [4:0] flg_q, core_flg;
  logic [15:0] cnt_q;
  logic idle, g0, g1, acc, hs;
  fp_mul_core #(.EXP(EXP), .MAN(MAN), .BITS(BITS), .BIAS(BIAS)) u_core (
    .x_i(x_q), .y_i(y_q), .result_o(core_res), .flags_o(core_flg)
  );
  // rr_q names the requester that wins when both are valid.
  assign g0   = bus.req0_valid & (~bus.req1_valid | ~rr_q);
  assign g1   = bus.req1_valid & (~bus.req0_valid | rr_q);
  assign idle = state_q == IDLE;
  assign acc  = idle & (g0 | g1);
  assign hs   = (state_q == DONE) & bus.resp_ready;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = acc ? CALC : IDLE;
      CALC:    state_d = DONE;
      DONE:    state_d = hs ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        x_q  <= g1 ? bus.req1_x : bus.req0_x;
        y_q  <= g1 ? bus.req1_y : bus.req0_y;
        id_q <= g1;
        rr_q <= ~g1;
      end
      if (state_q == CALC) begin
        res_q <= core_res;
        flg_q <= core_flg;
      end
      if (hs) cnt_q <= cnt_q + 16'd1;
    end
  end
  assign bus.req0_ready  = resetn & idle & g0;
  assign bus.req1_ready  = resetn & idle & g1;
  assign bus.resp_valid  = state_q == DONE;
  assign bus.resp_id     = id_q;
  assign bus.resp_result = res_q;
  assign bus.resp_flags  = flg_q;
  assign bus.op_count    = cnt_q;
endmodule

// File: tb/tb_fpmul_arbiter.sv
// tb_fpmul_arbiter: directed vector table plus back-pressure, round-robin and mid-op reset sequences.
module tb_fpmul_arbiter;
  logic clk = 1'b0;
  logic resetn;
  int ntests = 0;
  int nfail = 0;
  fpmul_arbiter_if bus ();
  fpmul_arbiter dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    int          id;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    logic [4:0]  f;
  } vec_t;
  vec_t tv[9];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_op(input int id, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic [4:0] ef, input int cnt);
    int n;
    if (id == 0) begin
      bus.req0_valid = 1'b1; bus.req0_x = x; bus.req0_y = y;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_x = x; bus.req1_y = y;
    end
    #1;
    n = 0;
    while (!(id == 0 ? bus.req0_ready : bus.req1_ready) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    check("accept_in_time", 32'(n < 10), 32'd1);
    check("other_ready_low", 32'(id == 0 ? bus.req1_ready : bus.req0_ready), 32'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    check("calc_no_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk); #1;
    check("resp_valid", 32'(bus.resp_valid), 32'd1);
    check("resp_id", 32'(bus.resp_id), 32'(id));
    check("resp_result", bus.resp_result, er);
    check("resp_flags", 32'(bus.resp_flags), 32'(ef));
    @(negedge clk); #1;
    check("op_count", 32'(bus.op_count), 32'(cnt));
    check("resp_valid_cleared", 32'(bus.resp_valid), 32'd0);
  endtask
  initial begin
    int ids[$];
    int cyc[$];
    int viol;
    tv[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000, 5'b00000};
    tv[1] = '{1, 32'hC0000000, 32'h40400000, 32'hC0C00000, 5'b00000};
    tv[2] = '{0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 5'b00000};
    tv[3] = '{1, 32'h00000000, 32'h40400000, 32'h00000000, 5'b00100};
    tv[4] = '{0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 5'b10000};
    tv[5] = '{1, 32'h7FC00000, 32'h3F800000, 32'h7F800000, 5'b01000};
    tv[6] = '{0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b00010};
    tv[7] = '{1, 32'h00800000, 32'h00800000, 32'h00000000, 5'b00001};
    tv[8] = '{0, 32'hBF800000, 32'hBF800000, 32'h3F800000, 5'b00000};
    resetn = 1'b0;
    bus.resp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_x = 32'h40000000; bus.req0_y = 32'h40400000;
    bus.req1_valid = 1'b1; bus.req1_x = 32'h40000000; bus.req1_y = 32'h40400000;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_ready1", 32'(bus.req1_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_id", 32'(bus.resp_id), 32'd0);
    check("rst_resp_result", bus.resp_result, 32'd0);
    check("rst_resp_flags", 32'(bus.resp_flags), 32'd0);
    check("rst_op_count", 32'(bus.op_count), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 9; i++) do_op(tv[i].id, tv[i].x, tv[i].y, tv[i].r, tv[i].f, i + 1);
    // Back-pressure: hold resp_ready low for 5 DONE cycles while req1 waits.
    bus.resp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_x = 32'h40000000; bus.req0_y = 32'h40400000;
    #1;
    check("bp_accept", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_x = 32'h3FC00000; bus.req1_y = 32'h3FC00000;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_valid", 32'(bus.resp_valid), 32'd1);
      check("bp_result", bus.resp_result, 32'h40C00000);
      check("bp_flags", 32'(bus.resp_flags), 32'd0);
      check("bp_id", 32'(bus.resp_id), 32'd0);
      check("bp_no_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
      check("bp_count", 32'(bus.op_count), 32'd9);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    bus.req1_valid = 1'b0;
    @(negedge clk); #1;
    check("bp_count_after", 32'(bus.op_count), 32'd10);
    check("bp_valid_after", 32'(bus.resp_valid), 32'd0);
    // Round robin: both valid every cycle straight out of reset.
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_x = 32'h40000000; bus.req0_y = 32'h40400000;
    bus.req1_valid = 1'b1; bus.req1_x = 32'hC0000000; bus.req1_y = 32'h40400000;
    viol = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) viol++;
      if (bus.resp_valid) begin
        ids.push_back(int'(bus.resp_id));
        cyc.push_back(c);
        check("rr_result", bus.resp_result, bus.resp_id ? 32'hC0C00000 : 32'h40C00000);
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    check("rr_no_double_ready", 32'(viol), 32'd0);
    check("rr_nresp", 32'(ids.size()), 32'd4);
    if (ids.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        check("rr_id", 32'(ids[j]), 32'(j % 2));
        check("rr_cycle", 32'(cyc[j]), 32'(2 + 3 * j));
      end
    end
    check("rr_count", 32'(bus.op_count), 32'd4);
    // Reset during CALC discards the operation.
    bus.req0_valid = 1'b1; bus.req0_x = 32'h40000000; bus.req0_y = 32'h40400000;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rst_calc_no_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_calc_count", 32'(bus.op_count), 32'd0);
      @(negedge clk);
    end
    do_op(1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 5'b00000, 1);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/fpmul_arbiter.md
# fpmul_arbiter

Shares one single-precision (parameterizable) floating-point multiplier between two requesters. Round-robin arbitration on valid/ready request channels, one operation in flight, result returned on a single tagged valid/ready response channel with the five special-case flags. Sits between the lab's operand sources (e.g. two processor-side ports) and the combinational FP multiply datapath, registering operands and results so the multiplier is off the external timing paths.

## Interface
- EXP, 8, exponent width
- MAN, 23, mantissa width (hidden bit excluded)
- BITS, MAN+EXP+1, operand/result width
- BIAS, 2**(EXP-1)-1, exponent bias
- clk  input  1  clock, all state updates on rising edge
- resetn  input  1  reset; synchronous, active-low
- req0_valid / req1_valid  input  1  requester k has operands
- req0_ready / req1_ready  output  1  requester k accepted this cycle
- req0_x, req0_y / req1_x, req1_y  input  BITS  operands, sign|exp|man
- resp_valid  output  1  result available
- resp_ready  input  1  consumer takes result
- resp_id  output  1  requester that issued the result
- resp_result  output  BITS  product
- resp_flags  output  5  {inf, nan, zero, overflow, underflow}
- op_count  output  16  completed responses, wraps 0xFFFF→0

## Operation
- FSM: IDLE → CALC → DONE → IDLE. Reset state IDLE.
- IDLE: grant computed from valids. One valid → that requester. Both valid → requester selected by rr_ptr. reqk_ready = (state==IDLE) & grant_k; combinational from valid, never asserted to both. Handshake (valid&ready) latches x, y, id into operand regs, sets rr_ptr to the other requester, → CALC. No valid → stay, rr_ptr unchanged.
- CALC: core evaluates latched operands; result and flags registered; → DONE.
- DONE: resp_valid=1; resp_id/result/flags stable until resp_valid&resp_ready; then op_count+1, → IDLE.
- Requesters must hold x/y stable while valid and not ready; valid must not depend on ready.
- Core arithmetic: sign = xs^ys; exp = ex+ey-BIAS (EXP bits, wraps); man = truncated product of {1,mx}*{1,my}, shifted right one and exp+1 when product bit 2*MAN+1 set; no rounding; subnormals treated as normal encoding.
- Flag priority, exactly one or none set: zero (either operand magnitude 0 or packed product magnitude 0) → result 0; nan (operand or product exp all-ones, man≠0) → {0,1s,0s}; inf (same, man=0) → {0,1s,0s}; underflow (ex+ey<BIAS, EXP+1-bit sum) → 0; overflow (ex+ey>3*BIAS) → {0,1s,0s}; else signed product, flags 0.

## Timing
- Reset: state IDLE, rr_ptr=0, resp_valid=0, resp_id=0, resp_result=0, resp_flags=0, op_count=0, req*_ready=0 during reset cycle.
- Request accepted at edge ending cycle A; resp_valid high from cycle A+2; earliest next accept in cycle after response handshake. Minimum 3 cycles/op.
- resp_ready held high at DONE: handshake in first DONE cycle.
- resetn low in CALC or DONE: operation discarded, no response, op_count unchanged by it, outputs at reset values next cycle.
- op_count increments exactly on response handshake.

## Structure
- Package fpmul_pkg: flag index constants (FLG_INF..FLG_UNF), state enum {IDLE,CALC,DONE}, special exponent constant helper.
- Sub-module fp_mul_core: purely combinational X,Y → result + flags per arithmetic rules above; the arbiter instantiates it once on the operand registers.

## Test plan
- Req0 only, 0x40000000 × 0x40400000 -> resp in cycle A+2: result 0x40C00000, id 0, flags 00000, op_count 1.
- Req1 0xC0000000 × 0x40400000 -> 0xC0C00000; 0x3FC00000 × 0x3FC00000 -> 0x40100000, flags 0.
- Both valid every cycle after reset with resp_ready=1 -> ids alternate 0,1,0,1; no ready to both; 3-cycle spacing.
- Specials: 0x00000000×0x40400000 -> 0, 00100; 0x7F800000×0x3F800000 -> 0x7F800000, 10000; 0x7FC00000×0x3F800000 -> 0x7F800000, 01000; 0x7F000000×0x7F000000 -> 0x7F800000, 00010; 0x00800000×0x00800000 -> 0, 00001.
- resp_ready low 5 cycles in DONE -> resp_* stable, both req_ready low, op_count unchanged until handshake.
- resetn low for 1 cycle during CALC -> no resp_valid, op_count 0, next request from req1 with rr_ptr back at 0 served normally.
